// File: rtl/wav_dfi_hs_pkg.sv
// Shared types and constants for the DFI req/ack handshake checker.
package wav_dfi_hs_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, GRANT, RELEASE} hs_state_e;

   localparam int ERR_PROTO      = 0;
   localparam int ERR_RESP_TO    = 1;
   localparam int ERR_REL_TO     = 2;
   localparam int ERR_ABORT_EXCL = 3;

   localparam int CTRLUPD = 0;
   localparam int PHYUPD  = 1;
   localparam int PHYMSTR = 2;
   localparam int LP_CTRL = 3;
   localparam int LP_DATA = 4;

endpackage

// File: rtl/wav_dfi_hs_chan.sv
// One handshake channel: protocol FSM, shared wait/release timer and
// worst-case latency capture. Error events are single-cycle pulses.
module wav_dfi_hs_chan
   import wav_dfi_hs_pkg::*;
#(
   parameter int TMR_W   = 10,
   parameter int NUM_ERR = 4
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               en_i,
   input  logic               req_i,
   input  logic               ack_i,
   input  logic [TMR_W-1:0]   resp_max_i,
   input  logic [TMR_W-1:0]   rel_max_i,
   input  logic               abort_ok_i,
   input  logic               clr_i,
   output logic [NUM_ERR-1:0] ev_o,
   output logic               busy_o,
   output logic [TMR_W-1:0]   lat_max_o
);

   localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

   hs_state_e        state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d, tmr_inc;
   logic [TMR_W-1:0] lat_q, lat_d;
   logic             fired_q, fired_d;
   logic             ack_q;
   logic             lat_upd;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      fired_d = fired_q;
      ev_o    = '0;
      lat_upd = 1'b0;
      tmr_inc = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
      if (!en_i) begin
         state_d = IDLE;
         tmr_d   = '0;
         fired_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_i) begin
                  state_d = ack_i ? GRANT : WAIT;
                  tmr_d   = ack_i ? '0 : TMR_ONE;
                  fired_d = 1'b0;
               end else if (ack_i && !ack_q) begin
                  ev_o[ERR_PROTO] = 1'b1;
               end
            end
            WAIT: begin
               if (ack_i) begin
                  state_d = GRANT;
                  lat_upd = 1'b1;
               end else if (!req_i) begin
                  state_d = IDLE;
                  tmr_d   = '0;
                  ev_o[ERR_ABORT_EXCL] = !abort_ok_i;
               end else begin
                  tmr_d = tmr_inc;
                  // fired_q keeps a saturated timer from re-raising the timeout
                  if (tmr_q == resp_max_i && resp_max_i != '0 && !fired_q) begin
                     ev_o[ERR_RESP_TO] = 1'b1;
                     fired_d           = 1'b1;
                  end
               end
            end
            GRANT: begin
               if (!req_i && !ack_i) begin
                  state_d = IDLE;
                  tmr_d   = '0;
               end else if (!req_i && ack_i) begin
                  state_d = RELEASE;
                  tmr_d   = TMR_ONE;
                  fired_d = 1'b0;
               end else if (req_i && !ack_i) begin
                  ev_o[ERR_PROTO] = 1'b1;
                  state_d = WAIT;
                  tmr_d   = TMR_ONE;
                  fired_d = 1'b0;
               end
            end
            RELEASE: begin
               if (!ack_i) begin
                  state_d = IDLE;
                  tmr_d   = '0;
               end else begin
                  tmr_d = tmr_inc;
                  if (req_i) ev_o[ERR_PROTO] = 1'b1;
                  if (tmr_q == rel_max_i && rel_max_i != '0 && !fired_q) begin
                     ev_o[ERR_REL_TO] = 1'b1;
                     fired_d          = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      lat_d = clr_i ? '0 : lat_q;
      if (lat_upd && tmr_q > lat_d) lat_d = tmr_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         fired_q <= 1'b0;
         ack_q   <= 1'b0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         fired_q <= fired_d;
         ack_q   <= ack_i;
         lat_q   <= lat_d;
      end
   end

   assign busy_o    = (state_q != IDLE);
   assign lat_max_o = lat_q;

endmodule

// File: rtl/wav_dfi_hs_checker.sv
// Generic DFI handshake checker: NUM_CH req/ack channels plus cross-channel
// ack exclusivity, with sticky flags and saturating per-channel event counts.
module wav_dfi_hs_checker
   import wav_dfi_hs_pkg::*;
#(
   parameter int NUM_CH  = 5,
   parameter int TMR_W   = 10,
   parameter int CNT_W   = 8,
   parameter int NUM_ERR = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      en,
   input  logic [NUM_CH-1:0]         req,
   input  logic [NUM_CH-1:0]         ack,
   input  logic [NUM_CH*TMR_W-1:0]   cfg_resp_max,
   input  logic [TMR_W-1:0]          cfg_rel_max,
   input  logic [NUM_CH-1:0]         cfg_abort_ok,
   input  logic [NUM_CH*NUM_CH-1:0]  cfg_excl,
   input  logic                      err_clr,
   output logic [NUM_CH*NUM_ERR-1:0] err_sticky,
   output logic                      err_any,
   output logic [NUM_CH*CNT_W-1:0]   err_cnt,
   output logic [NUM_CH-1:0]         busy,
   output logic [NUM_CH*TMR_W-1:0]   lat_max
);

   logic [NUM_CH-1:0] excl_hit;

   // Either direction of the matrix arms the check for a pair.
   always_comb begin
      excl_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         for (int j = 0; j < NUM_CH; j++) begin
            if (i != j && ack[i] && ack[j] &&
                (cfg_excl[i*NUM_CH+j] || cfg_excl[j*NUM_CH+i]))
               excl_hit[i] = 1'b1;
         end
      end
      if (!en) excl_hit = '0;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [NUM_ERR-1:0] chan_ev, ev, stk_q, stk_d;
      logic [CNT_W-1:0]   cnt_q, cnt_d;

      wav_dfi_hs_chan #(.TMR_W(TMR_W), .NUM_ERR(NUM_ERR)) u_chan (
         .clk_i      (clock),
         .rst_n_i    (reset),
         .en_i       (en),
         .req_i      (req[g]),
         .ack_i      (ack[g]),
         .resp_max_i (cfg_resp_max[g*TMR_W +: TMR_W]),
         .rel_max_i  (cfg_rel_max),
         .abort_ok_i (cfg_abort_ok[g]),
         .clr_i      (err_clr),
         .ev_o       (chan_ev),
         .busy_o     (busy[g]),
         .lat_max_o  (lat_max[g*TMR_W +: TMR_W])
      );

      assign ev = chan_ev | (NUM_ERR'(excl_hit[g]) << ERR_ABORT_EXCL);

      // A same-cycle event survives the clear.
      always_comb begin
         stk_d = (err_clr ? '0 : stk_q) | ev;
         cnt_d = err_clr ? '0 : cnt_q;
         if (|ev && cnt_d != '1) cnt_d = cnt_d + 1'b1;
      end

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            stk_q <= '0;
            cnt_q <= '0;
         end else begin
            stk_q <= stk_d;
            cnt_q <= cnt_d;
         end
      end

      assign err_sticky[g*NUM_ERR +: NUM_ERR] = stk_q;
      assign err_cnt[g*CNT_W +: CNT_W]        = cnt_q;
   end

   assign err_any = |err_sticky;

endmodule
